// File: rtl/row_result_quantizer_if.sv
// row_result_quantizer_if: accumulator input stream and quantized output stream of one array row.
interface row_result_quantizer_if #(
    parameter int accw = 28,
    parameter int dw = 11
);
    logic signed [accw-1:0] acc_in;
    logic acc_valid;
    logic acc_ready;
    logic signed [dw-1:0] out_data;
    logic out_valid;
    logic out_ready;
    modport master (output acc_in, acc_valid, out_ready, input acc_ready, out_data, out_valid);
    modport slave (input acc_in, acc_valid, out_ready, output acc_ready, out_data, out_valid);
endinterface

// File: rtl/row_result_quantizer.sv
// row_result_quantizer: bias add, rounding shift, ReLU and saturation of a row sum, buffered in a FWFT FIFO.
module row_result_quantizer #(
    parameter int columns = 64,
    parameter int datawidth = 11,
    parameter int fifo_depth = 4,
    localparam int ACCW = 2*datawidth + $clog2(columns),
    localparam int SHW = $clog2(ACCW+1)
) (
    input  logic clk,
    input  logic rst_overall_n,
    input  logic rst_vals,
    row_result_quantizer_if.slave bus,
    input  logic signed [datawidth-1:0] bias,
    input  logic [SHW-1:0] shift,
    input  logic relu_en,
    output logic [7:0] sat_count
);
    localparam int AW = $clog2(fifo_depth);
    localparam logic signed [ACCW+1:0] MAXV = (ACCW+2)'(2**(datawidth-1)-1);
    localparam logic signed [ACCW+1:0] MINV = (ACCW+2)'(-(2**(datawidth-1)));
    localparam logic signed [datawidth-1:0] POS_SAT = {1'b0, {(datawidth-1){1'b1}}};
    localparam logic signed [datawidth-1:0] NEG_SAT = {1'b1, {(datawidth-1){1'b0}}};
    logic signed [ACCW:0] sum1;
    logic signed [ACCW+1:0] r2, ext, half, rnd, r_nxt;
    logic signed [datawidth-1:0] y3, y_nxt;
    logic signed [datawidth-1:0] mem [fifo_depth];
    logic [SHW-1:0] eff;
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic v1, v2, v3, sat3, sat_nxt, clamp, acc, push, pop;
    assign acc = bus.acc_valid && bus.acc_ready;
    assign push = v3;
    assign pop = bus.out_valid && bus.out_ready;
    assign bus.out_valid = cnt != '0;
    assign bus.out_data = bus.out_valid ? mem[rp] : '0;
    // Credits cover every result already in flight, so S3 never finds the FIFO full.
    assign bus.acc_ready = (AW+2)'(cnt) + (AW+2)'(v1) + (AW+2)'(v2) + (AW+2)'(v3) < (AW+2)'(fifo_depth);
    always_comb begin
        eff = shift > SHW'(ACCW-1) ? SHW'(ACCW-1) : shift;
        ext = {sum1[ACCW], sum1};
        half = eff == '0 ? '0 : (ACCW+2)'(1) << (eff - 1'b1);
        rnd = ext + half;
        r_nxt = rnd >>> eff;
        clamp = relu_en && r2[ACCW+1];
        sat_nxt = !clamp && (r2 > MAXV || r2 < MINV);
        y_nxt = clamp ? '0 : r2 > MAXV ? POS_SAT : r2 < MINV ? NEG_SAT : r2[datawidth-1:0];
    end
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            {v1, v2, v3, sat3} <= '0;
            sum1 <= '0;
            r2 <= '0;
            y3 <= '0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            sat_count <= '0;
        end else if (rst_vals) begin
            {v1, v2, v3, sat3} <= '0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            sat_count <= '0;
        end else begin
            v1 <= acc;
            sum1 <= {bus.acc_in[ACCW-1], bus.acc_in} + (ACCW+1)'(bias);
            v2 <= v1;
            r2 <= r_nxt;
            v3 <= v2;
            y3 <= y_nxt;
            sat3 <= v2 && sat_nxt;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (push && sat3 && sat_count != 8'hff) sat_count <= sat_count + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= y3;
    end
endmodule

// File: tb/tb_row_result_quantizer.sv
// tb_row_result_quantizer: vector table, hand-written corner sequences and randomized scoreboard run.
module tb_row_result_quantizer;
    localparam int COLS = 64, DW = 11, DEPTH = 4, ACCW = 28, SHW = 5;
    logic clk = 0, rst_overall_n = 0, rst_vals = 0, relu_en = 0;
    logic signed [DW-1:0] bias = '0;
    logic [SHW-1:0] shift = '0;
    logic [7:0] sat_count;
    row_result_quantizer_if #(.accw(ACCW), .dw(DW)) bus();
    row_result_quantizer #(.columns(COLS), .datawidth(DW), .fifo_depth(DEPTH)) dut (
        .clk(clk), .rst_overall_n(rst_overall_n), .rst_vals(rst_vals), .bus(bus.slave),
        .bias(bias), .shift(shift), .relu_en(relu_en), .sat_count(sat_count));
    always #5 clk = ~clk;
    typedef struct { longint acc; int b; int sh; bit relu; int y; int inc; } vec_t;
    vec_t vt [17];
    int checks = 0, errors = 0, model_sat = 0, exp_sat = 0, ey, my;
    bit ms;
    int exp_q [$];
    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask
    // Reference quantizer: plain integer arithmetic on the rules, floor division via signed shift.
    function automatic void quant(input longint a, input longint b, input int sh, input bit relu,
                                  output int y, output bit sat);
        longint s, r, hi, lo;
        int e;
        s = a + b;
        e = sh > ACCW-1 ? ACCW-1 : sh;
        r = e > 0 ? (s + (longint'(1) << (e-1))) >>> e : s;
        hi = 2**(DW-1) - 1;
        lo = -(2**(DW-1));
        sat = 0;
        if (relu && r < 0) y = 0;
        else if (r > hi) begin y = int'(hi); sat = 1; end
        else if (r < lo) begin y = int'(lo); sat = 1; end
        else y = int'(r);
    endfunction
    always @(negedge clk) begin
        if (rst_overall_n) begin
            if (rst_vals) begin
                exp_q.delete();
                model_sat = 0;
            end else begin
                if (bus.out_valid && exp_q.size() == 0) check("unexpected_out", longint'(bus.out_valid), 0);
                else if (bus.out_valid && bus.out_ready) begin
                    ey = exp_q.pop_front();
                    check("sb_out_data", longint'(bus.out_data), longint'(ey));
                end
                if (bus.acc_valid && bus.acc_ready) begin
                    quant(longint'(bus.acc_in), longint'(bias), int'(shift), relu_en, my, ms);
                    exp_q.push_back(my);
                    if (ms && model_sat < 255) model_sat++;
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drain(input int maxc);
        int n = 0;
        bus.out_ready = 1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < maxc) begin
            tick();
            n++;
        end
        check("drain_left", longint'(exp_q.size()), 0);
    endtask
    task automatic run_vec(input vec_t v);
        int n = 0;
        bias = DW'(v.b);
        shift = SHW'(v.sh);
        relu_en = v.relu;
        bus.out_ready = 1;
        bus.acc_in = ACCW'(v.acc);
        bus.acc_valid = 1;
        tick();
        bus.acc_valid = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        check("vec_latency", longint'(n), 3);
        check("vec_y", longint'(bus.out_data), longint'(v.y));
        exp_sat += v.inc;
        check("vec_sat", longint'(sat_count), longint'(exp_sat));
        tick();
        check("vec_valid_once", longint'(bus.out_valid), 0);
    endtask
    task automatic send(input int val);
        bus.acc_in = ACCW'(val);
        bus.acc_valid = 1;
        tick();
        bus.acc_valid = 0;
    endtask
    initial begin
        int acc_cnt;
        vt[0]  = '{100, 0, 0, 0, 100, 0};
        vt[1]  = '{-37, 0, 2, 0, -9, 0};
        vt[2]  = '{-37, 0, 2, 1, 0, 0};
        vt[3]  = '{6, 0, 2, 0, 2, 0};
        vt[4]  = '{134217727, 0, 0, 0, 1023, 1};
        vt[5]  = '{-134217728, 0, 0, 0, -1024, 1};
        vt[6]  = '{1047, -24, 0, 0, 1023, 0};
        vt[7]  = '{2047, 0, 1, 0, 1023, 1};
        vt[8]  = '{-2049, 0, 1, 0, -1024, 0};
        vt[9]  = '{-2051, 0, 1, 0, -1024, 1};
        vt[10] = '{7, 0, 31, 0, 0, 0};
        vt[11] = '{134217727, 0, 27, 0, 1, 0};
        vt[12] = '{-5000, 0, 0, 1, 0, 0};
        vt[13] = '{-5, 0, 1, 0, -2, 0};
        vt[14] = '{134217727, 1023, 0, 0, 1023, 1};
        vt[15] = '{1024, 0, 0, 0, 1023, 1};
        vt[16] = '{-1024, 0, 0, 0, -1024, 0};
        bus.acc_in = '0;
        bus.acc_valid = 0;
        bus.out_ready = 1;
        #2;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_sat_count", longint'(sat_count), 0);
        check("rst_acc_ready", longint'(bus.acc_ready), 1);
        #10 rst_overall_n = 1;
        tick();
        foreach (vt[i]) run_vec(vt[i]);
        bias = '0;
        shift = '0;
        relu_en = 0;
        bus.out_ready = 0;
        acc_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.acc_in = ACCW'(i);
            bus.acc_valid = 1;
            @(negedge clk);
            if (bus.acc_ready) acc_cnt++;
            tick();
        end
        bus.acc_valid = 0;
        tick();
        check("bp_accepted", longint'(acc_cnt), 4);
        check("bp_ready_low", longint'(bus.acc_ready), 0);
        bus.out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            check("bp_seq", longint'(bus.out_data), longint'(k));
            tick();
        end
        check("bp_empty", longint'(bus.out_valid), 0);
        check("bp_ready_back", longint'(bus.acc_ready), 1);
        send(5);
        send(6);
        drain(20);
        bus.out_ready = 0;
        send(10);
        send(20);
        send(30);
        repeat (4) tick();
        check("ar_buffered", longint'(bus.out_valid), 1);
        #3 rst_overall_n = 0;
        #1;
        check("ar_out_valid", longint'(bus.out_valid), 0);
        check("ar_sat_count", longint'(sat_count), 0);
        check("ar_acc_ready", longint'(bus.acc_ready), 1);
        exp_q.delete();
        model_sat = 0;
        exp_sat = 0;
        #2 rst_overall_n = 1;
        bus.out_ready = 1;
        repeat (6) begin
            tick();
            check("ar_no_stale", longint'(bus.out_valid), 0);
        end
        run_vec(vt[4]);
        bus.out_ready = 0;
        send(3);
        send(4);
        repeat (4) tick();
        check("rv_buffered", longint'(bus.out_valid), 1);
        rst_vals = 1;
        bus.acc_in = ACCW'(50);
        bus.acc_valid = 1;
        tick();
        rst_vals = 0;
        bus.acc_valid = 0;
        exp_sat = 0;
        check("rv_out_valid", longint'(bus.out_valid), 0);
        check("rv_sat_count", longint'(sat_count), 0);
        check("rv_acc_ready", longint'(bus.acc_ready), 1);
        bus.out_ready = 1;
        repeat (6) begin
            tick();
            check("rv_no_50", longint'(bus.out_valid), 0);
        end
        run_vec(vt[1]);
        run_vec(vt[5]);
        for (int ph = 0; ph < 4; ph++) begin
            bias = DW'($urandom);
            shift = SHW'($urandom_range(0, 31));
            relu_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < 250; c++) begin
                bus.acc_valid = $urandom_range(0, 3) != 0;
                bus.out_ready = $urandom_range(0, 3) != 0;
                bus.acc_in = $urandom_range(0, 1) != 0 ? ACCW'($urandom)
                                                       : ACCW'(int'($urandom_range(0, 8191)) - 4096);
                tick();
            end
            bus.acc_valid = 0;
            drain(50);
            check("rand_sat", longint'(sat_count), longint'(model_sat));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end
endmodule

// File: doc/row_result_quantizer.md
# row_result_quantizer

Downstream consumer of the east edge of one systolic-array row: accepts the final accumulated partial sum from the last column's processing block and adds a per-row bias. It then applies a rounding arithmetic right shift, optional ReLU, and saturation back to `datawidth` bits. Results are buffered in a small FIFO and presented on a valid/ready interface to the next layer's input feeder. One instance per array row.

## Interface
Parameters:
- `columns`, 64, number of array columns; sets accumulator guard bits.
- `datawidth`, 11, signed width of weights/activations and of the output.
- `fifo_depth`, 4, output FIFO entries (power of two, ≥2).
- Derived: ACCW = 2*datawidth + $clog2(columns) (28 at defaults); SHW = $clog2(ACCW+1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_overall_n`  in  1  asynchronous, active-low reset.
- `rst_vals`  in  1  synchronous clear of pipeline, FIFO and counter; config untouched.
- `acc_in`  in  ACCW signed  row sum from last column's `outp_east`.
- `acc_valid`  in  1  `acc_in` valid this cycle.
- `acc_ready`  out  1  block can accept `acc_in`.
- `bias`  in  datawidth signed  per-row bias, accumulator scale; quasi-static.
- `shift`  in  SHW unsigned  right-shift amount; quasi-static.
- `relu_en`  in  1  clamp negatives to 0.
- `out_data`  out  datawidth signed  quantized result, FIFO head.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `sat_count`  out  8  number of saturated results, sticks at 255.

## Operation
- Transfer in: `acc_valid && acc_ready` on an edge. Transfer out: `out_valid && out_ready` on an edge.
- Three-stage pipeline, each stage a register plus valid bit. The pipeline never stalls:
  - S1: sum = sext(acc_in, ACCW+1) + sext(bias, ACCW+1).
  - S2: eff = min(shift, ACCW−1). If eff>0, r = (sext(sum, ACCW+2) + (1<<(eff−1))) >>> eff; otherwise r = sum. This is round-half-up; e.g. −37, shift 2 → −9.
  - S3: if `relu_en` and r<0, y=0. Otherwise, if r>2^(datawidth−1)−1, y=POS_SAT and the counter increments; if r<−2^(datawidth−1), y=NEG_SAT and the counter increments; otherwise y=r[datawidth−1:0]. y is pushed into the FIFO.
- ReLU-clamped values never count as saturations.
- Credit flow control: `acc_ready` = (FIFO occupancy + S1/S2/S3 valid bits) < fifo_depth. This guarantees S3 always has space to push.
- FIFO: first-word-fall-through, in-order, circular pointers with wrap at fifo_depth. A push and a pop on the same edge leave occupancy unchanged. A pop when empty cannot occur because `out_valid`=0.
- Reset `rst_overall_n`=0 (asynchronous), all outputs:
  - `out_valid`=0, `out_data`=0, `sat_count`=0.
  - `acc_ready`=1 (combinational, from cleared state).
  - Pipeline valid bits and FIFO pointers cleared.
  - Any in-flight or buffered data is discarded.
- `rst_vals`=1: same clearing, applied on the edge. It takes priority over a coincident `acc_valid` (that input is dropped) and a coincident pop.
- `bias`, `shift`, `relu_en` are sampled by the stage that uses them. Changing them while data is in flight is allowed, but results for in-flight entries are then mixed; the bench changes them only when idle.

## Timing
- Accept on edge k → pushed into FIFO on edge k+3 → `out_valid`=1 after edge k+3 if the FIFO was empty (latency 3).
- Throughput: 1 result/cycle while `out_ready`=1.
- `acc_ready` and `out_valid` are combinational from registered state only, with no paths from `acc_valid`/`out_ready`.
- `sat_count` updates on the same edge as the S3 push.

## Test plan
- Latency: bias=0, shift=0, relu_en=0, out_ready=1; acc_in=100 accepted at edge k → out_data=100, out_valid high after edge k+3 for exactly one cycle.
- Rounding/ReLU: acc_in=−37, bias=0, shift=2, relu_en=0 → −9. Same with relu_en=1 → 0, sat_count unchanged. acc_in=6, shift=2 → 2 (1.5 rounds up).
- Saturation: shift=0; acc_in=2^27−1 → 1023 and sat_count=1; then acc_in=−2^27 → −1024 and sat_count=2. Bias=−24 with acc_in=1047 → 1023 with no saturation.
- Backpressure: out_ready=0; drive acc_valid for 6 cycles with values 1..6 → exactly 4 accepted and acc_ready low. Raise out_ready → out_data sequence 1,2,3,4 with no loss or duplication. acc_ready returns high, and 5,6 then flow.
- Async reset mid-operation: FIFO holding 3 entries; rst_overall_n pulsed low between edges → out_valid=0, sat_count=0, acc_ready=1 immediately. Post-release, no stale outputs appear.
- rst_vals coincident with acc_valid=1 (acc_in=50) while 2 entries are buffered → next cycle out_valid=0. The 50 never appears, and bias/shift behaviour afterwards is unchanged.
